// File: rtl/control_sequencer.sv
// Hardwired control unit for dataPath: fetch (T0-T2) followed by per-opcode execute states.
// State advances on the falling clock edge so strobes settle before dataPath's rising edge.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IRval,
    input  logic        stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zlowin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPc,
    output logic        read,
    output logic        write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic [1:0]  mdr_read,
    output logic [3:0]  control,
    output logic        run
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;

    typedef enum logic [3:0] {
        StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    state_e state_q, state_d;

    logic [4:0] opcode;
    logic       unused_ir;
    logic       is_ld, is_ldi, is_st, is_addi, is_alu, is_exec, is_long;
    logic [3:0] alu_code;
    state_e     done_state;

    assign opcode    = IRval[31:27];
    assign unused_ir = ^IRval[26:0];

    assign is_ld   = (opcode == OP_LD);
    assign is_ldi  = (opcode == OP_LDI);
    assign is_st   = (opcode == OP_ST);
    assign is_addi = (opcode == OP_ADDI);
    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
    assign is_exec = is_ld || is_ldi || is_st || is_addi || is_alu;
    assign is_long = is_ld || is_st;

    // Instruction boundary: stop diverts to HALT instead of the next fetch.
    assign done_state = stop ? StHalt : StT0;

    always_comb begin
        alu_code = ALU_ADD;
        case (opcode)
            OP_SUB:  alu_code = ALU_SUB;
            OP_AND:  alu_code = ALU_AND;
            OP_OR:   alu_code = ALU_OR;
            default: alu_code = ALU_ADD;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: state_d = StT0;
            StT0:    state_d = StT1;
            StT1:    state_d = StT2;
            StT2: begin
                if (opcode == OP_HALT) begin
                    state_d = StHalt;
                end else if (is_exec) begin
                    state_d = StT3;
                end else begin
                    // nop and unrecognised opcodes end after fetch
                    state_d = done_state;
                end
            end
            StT3:    state_d = StT4;
            StT4:    state_d = StT5;
            StT5:    state_d = is_long ? StT6 : done_state;
            StT6:    state_d = StT7;
            StT7:    state_d = done_state;
            StHalt:  state_d = StHalt;
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        Zlowin   = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        IncPc    = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        BAout    = 1'b0;
        Cout     = 1'b0;
        mdr_read = 2'b00;
        control  = ALU_ADD;
        run      = (state_q != StHalt);
        case (state_q)
            StT0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPc  = 1'b1;
                Zlowin = 1'b1;
            end
            StT1: begin
                Zlowout  = 1'b1;
                PCin     = 1'b1;
                read     = 1'b1;
                MDRin    = 1'b1;
                mdr_read = 2'b01;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                Grb = 1'b1;
                Yin = 1'b1;
                if (is_alu || is_addi) begin
                    Rout = 1'b1;
                end else begin
                    BAout = 1'b1;
                end
            end
            StT4: begin
                Zlowin = 1'b1;
                if (is_alu) begin
                    Grc     = 1'b1;
                    Rout    = 1'b1;
                    control = alu_code;
                end else begin
                    Cout = 1'b1;
                end
            end
            StT5: begin
                Zlowout = 1'b1;
                if (is_long) begin
                    MARin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            StT6: begin
                MDRin = 1'b1;
                if (is_st) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                end else begin
                    read     = 1'b1;
                    mdr_read = 2'b01;
                end
            end
            StT7: begin
                if (is_st) begin
                    write = 1'b1;
                end else begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class state by state and
// compares the full strobe vector against hand-written expectations.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IRval;
    logic        stop;
    logic        PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPc;
    logic        read, write, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic [1:0]  mdr_read;
    logic [3:0]  control;
    logic        run;

    int tests_run    = 0;
    int tests_failed = 0;

    control_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .IRval    (IRval),
        .stop     (stop),
        .PCout    (PCout),
        .Zlowout  (Zlowout),
        .MDRout   (MDRout),
        .MARin    (MARin),
        .Zlowin   (Zlowin),
        .PCin     (PCin),
        .MDRin    (MDRin),
        .IRin     (IRin),
        .Yin      (Yin),
        .IncPc    (IncPc),
        .read     (read),
        .write    (write),
        .Gra      (Gra),
        .Grb      (Grb),
        .Grc      (Grc),
        .Rin      (Rin),
        .Rout     (Rout),
        .BAout    (BAout),
        .Cout     (Cout),
        .mdr_read (mdr_read),
        .control  (control),
        .run      (run)
    );

    always #5 clk = ~clk;

    // Strobe masks, packed in the same order as obs below.
    localparam logic [18:0] MaskPcOut   = 19'h40000;
    localparam logic [18:0] MaskZlowOut = 19'h20000;
    localparam logic [18:0] MaskMdrOut  = 19'h10000;
    localparam logic [18:0] MaskMarIn   = 19'h08000;
    localparam logic [18:0] MaskZlowIn  = 19'h04000;
    localparam logic [18:0] MaskPcIn    = 19'h02000;
    localparam logic [18:0] MaskMdrIn   = 19'h01000;
    localparam logic [18:0] MaskIrIn    = 19'h00800;
    localparam logic [18:0] MaskYIn     = 19'h00400;
    localparam logic [18:0] MaskIncPc   = 19'h00200;
    localparam logic [18:0] MaskRead    = 19'h00100;
    localparam logic [18:0] MaskWrite   = 19'h00080;
    localparam logic [18:0] MaskGra     = 19'h00040;
    localparam logic [18:0] MaskGrb     = 19'h00020;
    localparam logic [18:0] MaskGrc     = 19'h00010;
    localparam logic [18:0] MaskRIn     = 19'h00008;
    localparam logic [18:0] MaskROut    = 19'h00004;
    localparam logic [18:0] MaskBaOut   = 19'h00002;
    localparam logic [18:0] MaskCOut    = 19'h00001;

    logic [25:0] obs;
    assign obs = {run, control, mdr_read, PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin,
                  IRin, Yin, IncPc, read, write, Gra, Grb, Grc, Rin, Rout, BAout, Cout};

    function automatic logic [25:0] vec(input logic r, input logic [3:0] c, input logic [1:0] m,
                                        input logic [18:0] s);
        return {r, c, m, s};
    endfunction

    logic [25:0] v_rst, v_halt, v_t0, v_t1, v_t2;
    logic [25:0] v_ba_y, v_c_z, v_z_mar, v_rd_mdr, v_mdr_ra, v_rb_y, v_z_ra, v_st6, v_wr;

    task automatic check_eq(input string tag, input logic [25:0] got, input logic [25:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic step(input string tag, input logic [25:0] want);
        @(posedge clk);
        #1;
        check_eq(tag, obs, want);
    endtask

    task automatic fetch(input string tag, input logic [31:0] ir);
        step({tag, ":T0"}, v_t0);
        IRval = ir;
        step({tag, ":T1"}, v_t1);
        step({tag, ":T2"}, v_t2);
    endtask

    // Drop reset between clock edges; outputs must clear before the next falling edge.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_eq({tag, ":async_reset"}, obs, v_rst);
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    logic [31:0] alu_ir  [4] = '{32'h19890000, 32'h20000000, 32'h28000000, 32'h30000000};
    logic [3:0]  alu_ctl [4] = '{4'd2, 4'd3, 4'd0, 4'd1};

    initial begin
        v_rst    = vec(1'b1, 4'd2, 2'b00, 19'h0);
        v_halt   = vec(1'b0, 4'd2, 2'b00, 19'h0);
        v_t0     = vec(1'b1, 4'd2, 2'b00, MaskPcOut | MaskMarIn | MaskIncPc | MaskZlowIn);
        v_t1     = vec(1'b1, 4'd2, 2'b01, MaskZlowOut | MaskPcIn | MaskRead | MaskMdrIn);
        v_t2     = vec(1'b1, 4'd2, 2'b00, MaskMdrOut | MaskIrIn);
        v_ba_y   = vec(1'b1, 4'd2, 2'b00, MaskGrb | MaskBaOut | MaskYIn);
        v_c_z    = vec(1'b1, 4'd2, 2'b00, MaskCOut | MaskZlowIn);
        v_z_mar  = vec(1'b1, 4'd2, 2'b00, MaskZlowOut | MaskMarIn);
        v_rd_mdr = vec(1'b1, 4'd2, 2'b01, MaskRead | MaskMdrIn);
        v_mdr_ra = vec(1'b1, 4'd2, 2'b00, MaskMdrOut | MaskGra | MaskRIn);
        v_rb_y   = vec(1'b1, 4'd2, 2'b00, MaskGrb | MaskROut | MaskYIn);
        v_z_ra   = vec(1'b1, 4'd2, 2'b00, MaskZlowOut | MaskGra | MaskRIn);
        v_st6    = vec(1'b1, 4'd2, 2'b00, MaskGra | MaskROut | MaskMdrIn);
        v_wr     = vec(1'b1, 4'd2, 2'b00, MaskWrite);

        reset = 1'b0;
        stop  = 1'b0;
        IRval = 32'h00800055;
        @(posedge clk);
        @(posedge clk);
        #1 check_eq("reset_state", obs, v_rst);
        #1 reset = 1'b1;

        // ld r1,85
        fetch("ld", 32'h00800055);
        step("ld:T3", v_ba_y);
        step("ld:T4", v_c_z);
        step("ld:T5", v_z_mar);
        step("ld:T6", v_rd_mdr);
        step("ld:T7", v_mdr_ra);

        // add, sub, and, or
        for (int i = 0; i < 4; i++) begin
            fetch("alu", alu_ir[i]);
            step("alu:T3", v_rb_y);
            step("alu:T4", vec(1'b1, alu_ctl[i], 2'b00, MaskGrc | MaskROut | MaskZlowIn));
            step("alu:T5", v_z_ra);
        end

        fetch("st", 32'h10000000);
        step("st:T3", v_ba_y);
        step("st:T4", v_c_z);
        step("st:T5", v_z_mar);
        step("st:T6", v_st6);
        step("st:T7", v_wr);

        fetch("ldi", 32'h08000000);
        step("ldi:T3", v_ba_y);
        step("ldi:T4", v_c_z);
        step("ldi:T5", v_z_ra);

        fetch("nop", 32'hD0000000);
        fetch("unknown", 32'hF8000000);

        // Asynchronous reset in the middle of an ld
        fetch("ld_abort", 32'h00800055);
        step("ld_abort:T3", v_ba_y);
        step("ld_abort:T4", v_c_z);
        step("ld_abort:T5", v_z_mar);
        pulse_reset("ld_abort");

        fetch("halt", 32'hD8000000);
        for (int i = 0; i < 11; i++) begin
            step("halt:hold", v_halt);
        end
        pulse_reset("halt");

        fetch("addi_stop", 32'h60000000);
        stop = 1'b1;
        step("addi_stop:T3", v_rb_y);
        step("addi_stop:T4", v_c_z);
        step("addi_stop:T5", v_z_ra);
        step("addi_stop:halt", v_halt);
        step("addi_stop:halt2", v_halt);
        stop = 1'b0;
        pulse_reset("addi_stop");
        step("restart:T0", v_t0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
